// File: rtl/backprop_weight_update_if.sv
// Handshake and data bus between the weight-update stage and its controller.
// The master side issues start/load requests and vectors; the slave side owns the weight bank.
interface backprop_weight_update_if #(
  parameter int data_size = 4,
  parameter int size      = 3,
  parameter int in_size   = 3
);
  logic                                 start;
  logic                                 load_weights;
  logic [data_size*size-1:0]            cost_stream;
  logic [data_size*in_size-1:0]         x_stream;
  logic [data_size*size*in_size-1:0]    weight_in;
  logic [data_size*size*in_size-1:0]    weight_stream;
  logic                                 busy;
  logic                                 done;

  modport master (
    output start, load_weights, cost_stream, x_stream, weight_in,
    input  weight_stream, busy, done
  );

  modport slave (
    input  start, load_weights, cost_stream, x_stream, weight_in,
    output weight_stream, busy, done
  );
endinterface

// File: rtl/backprop_weight_update.sv
// Output-layer weight update: adds (cost[j]*x[i]) >>> lr_shift to each W[j][i] with saturation,
// one weight per clock, and presents the whole bank continuously on weight_stream.
module backprop_weight_update #(
  parameter int data_size = 4,
  parameter int size      = 3,
  parameter int in_size   = 3,
  parameter int lr_shift  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  backprop_weight_update_if.slave   bus
);
  localparam int N  = size * in_size;
  localparam int PW = 2 * data_size;
  localparam int SW = PW + 1;
  localparam int JW = (size > 1) ? $clog2(size) : 1;
  localparam int IW = (in_size > 1) ? $clog2(in_size) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (data_size - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  function automatic logic signed [data_size-1:0] sat(input logic signed [SW-1:0] s);
    if (s > SAT_HI)      return SAT_HI[data_size-1:0];
    else if (s < SAT_LO) return SAT_LO[data_size-1:0];
    else                 return s[data_size-1:0];
  endfunction

  state_t                        state_q, state_d;
  logic [data_size*size-1:0]     cost_q, cost_d;
  logic [data_size*in_size-1:0]  x_q, x_d;
  logic signed [data_size-1:0]   w_q [N];
  logic signed [data_size-1:0]   w_d [N];
  logic [JW-1:0]                 j_q, j_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [NW-1:0]                 n_q, n_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic signed [data_size-1:0]   cost_a [size];
  logic signed [data_size-1:0]   x_a [in_size];
  logic signed [PW-1:0]          prod;
  logic signed [PW-1:0]          delta;
  logic signed [SW-1:0]          sum;
  logic [data_size*N-1:0]        wstream;

  always_comb begin
    for (int k = 0; k < size; k++)    cost_a[k] = cost_q[(size-k)*data_size-1 -: data_size];
    for (int k = 0; k < in_size; k++) x_a[k]    = x_q[(in_size-k)*data_size-1 -: data_size];
    wstream = '0;
    for (int k = 0; k < N; k++)       wstream[(N-k)*data_size-1 -: data_size] = w_q[k];
  end

  // Gradient datapath for the weight currently addressed by (j, i, n)
  assign prod  = PW'(cost_a[j_q]) * PW'(x_a[i_q]);
  assign delta = prod >>> lr_shift;
  assign sum   = SW'(w_q[n_q]) + SW'(delta);

  always_comb begin
    state_d = state_q;
    cost_d  = cost_q;
    x_d     = x_q;
    w_d     = w_q;
    j_d     = j_q;
    i_d     = i_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_weights) begin
          for (int k = 0; k < N; k++) w_d[k] = bus.weight_in[(N-k)*data_size-1 -: data_size];
        end else if (bus.start) begin
          cost_d  = bus.cost_stream;
          x_d     = bus.x_stream;
          j_d     = '0;
          i_d     = '0;
          n_d     = '0;
          busy_d  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        w_d[n_q] = sat(sum);
        n_d      = n_q + NW'(1);
        // i runs fastest so the flat index n walks the bank in ascending order
        if (i_q == IW'(in_size - 1)) begin
          i_d = '0;
          if (j_q == JW'(size - 1)) begin
            j_d     = '0;
            n_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cost_q  <= '0;
      x_q     <= '0;
      for (int k = 0; k < N; k++) w_q[k] <= '0;
      j_q     <= '0;
      i_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cost_q  <= cost_d;
      x_q     <= x_d;
      w_q     <= w_d;
      j_q     <= j_d;
      i_q     <= i_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.weight_stream = wstream;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: doc/backprop_weight_update.md
Name: backprop_weight_update

Overview:
- Output-layer weight update stage that sits directly downstream of backprop_cost.
- Consumes the per-neuron error vector (cost = 2*(label - y)) and the layer's input activations.
- Updates a register bank of size*in_size signed weights sequentially, one weight per clock, under a start/busy/done handshake.
- Holds the current weights and presents them continuously for the forward layer to use.

Parameters:
- data_size, 4, width of every element (two's-complement signed).
- size, 3, number of output neurons (elements in cost_stream).
- in_size, 3, number of layer inputs (elements in x_stream).
- lr_shift, 1, learning rate as an arithmetic right shift applied to each product.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one update pass; sampled in IDLE only.
- cost_stream  input  data_size*size  error vector; element k at [(size-k)*data_size-1 -: data_size].
- x_stream  input  data_size*in_size  activation vector; element i at [(in_size-i)*data_size-1 -: data_size].
- load_weights  input  1  bulk-load weight_in into the bank; honoured in IDLE only.
- weight_in  input  data_size*size*in_size  initial weights; W[j][i] at flat index n=j*in_size+i, bits [(size*in_size-n)*data_size-1 -: data_size].
- weight_stream  output  data_size*size*in_size  current weight bank, same packing as weight_in, driven directly from registers.
- busy  output  1  high while in UPDATE.
- done  output  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (async, any state, including mid-pass):
  - state=IDLE; all weights=0; busy=0; done=0; j=i=0.
  - Captured vectors are cleared.
  - A pass aborted by reset is not resumed.
- States: IDLE, UPDATE, DONE.
- IDLE:
  - load_weights=1: bank<=weight_in at the edge; stay IDLE.
  - start=1 and load_weights=0: capture cost_stream and x_stream into internal registers; j=i=0; go to UPDATE.
  - If load_weights and start are both 1, the load wins and start is dropped (not queued).
- UPDATE:
  - Each edge updates exactly W[j][i] using the captured vectors. Order: j outer, i inner, so n=0..size*in_size-1 ascending.
  - After W[size-1][in_size-1] is written, go to DONE.
  - start and load_weights are ignored; changes on the input streams have no effect.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE. start is ignored in DONE.
- Latency:
  - The start edge is edge 0; weights are written at edges 1..N, N=size*in_size.
  - busy is high from edge 0 to edge N.
  - done is high from edge N to edge N+1.
  - Minimum start-to-start spacing is N+2 cycles.
- Arithmetic, all signed:
  - p = cost[j]*x[i], full 2*data_size-bit product.
  - d = p >>> lr_shift, arithmetic shift, rounding toward -inf.
  - s = W[j][i] + d at 2*data_size+1 bits.
  - Saturate s to [-2^(data_size-1), 2^(data_size-1)-1] and write it back.
- Sign convention: cost already equals label-minus-output, so the gradient is added, not subtracted.
- weight_stream mid-pass reflects partially updated weights; consumers must wait for done.
- Weights not yet visited in a pass keep their previous values.

Test Plan (defaults data_size=4, size=3, in_size=3, lr_shift=1):
- Reset values: assert rst mid-UPDATE (after 4 writes) -> weight_stream=0, busy=0, done=0 immediately without a clock edge; after release, state is IDLE and start is accepted.
- Basic pass: weights 0; cost={2,-2,0}, x={1,1,1}; pulse start -> busy high for 9 cycles, then done one cycle. Final W row0={1,1,1}, row1={-1,-1,-1}, row2={0,0,0}.
- Positive saturation: load W[0][0]=7, cost[0]=6, x[0]=7 -> d=21 -> W[0][0]=7 (clamped).
- Negative saturation: load W[0][0]=-8, cost[0]=-6, x[0]=7 -> d=-21 -> W[0][0]=-8 (clamped).
- Rounding: W=0, cost[1]=1, x[2]=-1 -> p=-1, d=-1 -> W[1][2]=-1 (floor, not truncate).
- Handshake priority:
  - load_weights and start together in IDLE -> bank=weight_in, no pass, busy stays 0.
  - start re-pulsed during UPDATE and in DONE -> ignored, exactly one done pulse.
  - Change cost_stream during UPDATE -> result uses the values captured at the start edge.
